// File: rtl/fpu_shift_pkg.sv
// Shared constants for the FPU pipelined barrel shifter: shift-mode encodings and
// the byte-granular coarse step used by the first pipeline stage.
package fpu_shift_pkg;

  localparam logic [1:0] SHIFT_LSL = 2'b00;
  localparam logic [1:0] SHIFT_LSR = 2'b01;
  localparam logic [1:0] SHIFT_ASR = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;

  localparam int unsigned SHIFT_COARSE_STEP = 8;

endpackage

// File: rtl/fpu_shift_fine_stage.sv
// Combinational 0-7 bit shifter in all four modes; also reports whether any set bit
// was shifted out (right shifts only), for IEEE sticky accumulation.
module fpu_shift_fine_stage
  import fpu_shift_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [2:0]       shamt_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] data_o,
  output logic             sticky_o
);

  logic [WIDTH-1:0] low_mask;
  logic [31:0]      rot_back;

  always_comb begin
    low_mask = ~({WIDTH{1'b1}} << shamt_i);
    rot_back = WIDTH - 32'(shamt_i);
    data_o   = data_i;
    sticky_o = 1'b0;
    unique case (mode_i)
      SHIFT_LSL: data_o = data_i << shamt_i;
      SHIFT_LSR: begin
        data_o   = data_i >> shamt_i;
        sticky_o = |(data_i & low_mask);
      end
      SHIFT_ASR: begin
        data_o   = $signed(data_i) >>> shamt_i;
        sticky_o = |(data_i & low_mask);
      end
      default: begin
        // A left shift by WIDTH yields zero, so shamt_i == 0 passes data through.
        data_o = (data_i >> shamt_i) | (data_i << rot_back);
      end
    endcase
  end

endmodule

// File: rtl/fpu_pipelined_shifter.sv
// Two-stage pipelined barrel shifter: stage 1 shifts by whole bytes, stage 2 by 0-7 bits,
// with sticky accumulation, a tag sideband and a valid/ready handshake with backpressure.
module fpu_pipelined_shifter
  import fpu_shift_pkg::*;
#(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned SHIFT_W = 7,
  parameter int unsigned TAG_W   = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHIFT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_sticky,
  output logic               out_zero,
  output logic [TAG_W-1:0]   out_tag
);

  // Stage-1 registers
  logic               s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]   s1_data_q, s1_data_d;
  logic [2:0]         s1_fine_q, s1_fine_d;
  logic [1:0]         s1_mode_q, s1_mode_d;
  logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;
  logic               s1_sticky_q, s1_sticky_d;

  // Output registers
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_sticky_q, out_sticky_d;
  logic               out_zero_q, out_zero_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;

  logic               s2_adv;
  logic               accept;

  logic [SHIFT_W-1:0] coarse_amt;
  logic [31:0]        rot_amt;
  logic [31:0]        rot_back;
  logic [WIDTH-1:0]   coarse_mask;
  logic [WIDTH-1:0]   coarse_data;
  logic               coarse_sticky;

  logic [WIDTH-1:0]   fine_data;
  logic               fine_sticky;

  assign s2_adv   = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;
  assign accept   = in_valid && in_ready;

  // Coarse stage. Amounts >= WIDTH saturate naturally: the shifts yield zero or all sign
  // bits, and the discard mask becomes all ones so sticky collapses to |in_data.
  always_comb begin
    coarse_amt    = {in_shamt[SHIFT_W-1:3], 3'b000};
    rot_amt       = 32'(coarse_amt) % WIDTH;
    rot_back      = WIDTH - rot_amt;
    coarse_mask   = ~({WIDTH{1'b1}} << coarse_amt);
    coarse_data   = in_data;
    coarse_sticky = 1'b0;
    unique case (in_mode)
      SHIFT_LSL: coarse_data = in_data << coarse_amt;
      SHIFT_LSR: begin
        coarse_data   = in_data >> coarse_amt;
        coarse_sticky = |(in_data & coarse_mask);
      end
      SHIFT_ASR: begin
        coarse_data   = $signed(in_data) >>> coarse_amt;
        coarse_sticky = |(in_data & coarse_mask);
      end
      default: coarse_data = (in_data >> rot_amt) | (in_data << rot_back);
    endcase
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_fine_d   = s1_fine_q;
    s1_mode_d   = s1_mode_q;
    s1_tag_d    = s1_tag_q;
    s1_sticky_d = s1_sticky_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
    end
    if (accept) begin
      s1_data_d   = coarse_data;
      s1_fine_d   = in_shamt[2:0];
      s1_mode_d   = in_mode;
      s1_tag_d    = in_tag;
      s1_sticky_d = coarse_sticky;
    end
  end

  fpu_shift_fine_stage #(
    .WIDTH (WIDTH)
  ) u_fine (
    .data_i   (s1_data_q),
    .shamt_i  (s1_fine_q),
    .mode_i   (s1_mode_q),
    .data_o   (fine_data),
    .sticky_o (fine_sticky)
  );

  // Outputs only move when the consumer is not stalling, which keeps them stable under
  // backpressure.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sticky_d = out_sticky_q;
    out_zero_d   = out_zero_q;
    out_tag_d    = out_tag_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d   = fine_data;
        out_sticky_d = s1_sticky_q | fine_sticky;
        out_zero_d   = (fine_data == '0);
        out_tag_d    = s1_tag_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      s1_fine_q    <= '0;
      s1_mode_q    <= SHIFT_LSL;
      s1_tag_q     <= '0;
      s1_sticky_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sticky_q <= 1'b0;
      out_zero_q   <= 1'b1;
      out_tag_q    <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_data_q    <= s1_data_d;
      s1_fine_q    <= s1_fine_d;
      s1_mode_q    <= s1_mode_d;
      s1_tag_q     <= s1_tag_d;
      s1_sticky_q  <= s1_sticky_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sticky_q <= out_sticky_d;
      out_zero_q   <= out_zero_d;
      out_tag_q    <= out_tag_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_sticky = out_sticky_q;
  assign out_zero   = out_zero_q;
  assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_fpu_pipelined_shifter.sv
// Bench for fpu_pipelined_shifter: directed vector table, backpressure, throughput,
// random stall and mid-flight reset sequences, scored against a bit-level reference model.
module tb_fpu_pipelined_shifter;
  import fpu_shift_pkg::*;

  localparam int W  = 64;
  localparam int SW = 7;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [SW-1:0] in_shamt = '0;
  logic [1:0]    in_mode = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_sticky;
  logic          out_zero;
  logic [TW-1:0] out_tag;

  fpu_pipelined_shifter #(
    .WIDTH   (W),
    .SHIFT_W (SW),
    .TAG_W   (TW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_shamt   (in_shamt),
    .in_mode    (in_mode),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sticky (out_sticky),
    .out_zero   (out_zero),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  data;
    logic          sticky;
    logic          zero;
    logic [TW-1:0] tag;
  } res_t;

  typedef struct {
    logic [1:0]    mode;
    logic [SW-1:0] shamt;
    logic [W-1:0]  data;
    logic [W-1:0]  exp_data;
    logic          exp_sticky;
    logic          exp_zero;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int          n_out = 0;
  bit          saw_stall = 0;
  res_t        exp_q[$];
  int unsigned out_cycles[$];
  logic [TW-1:0] got_tags[$];
  vec_t        vecs[12];

  // Reference: each result bit picked from the input by index arithmetic.
  function automatic res_t model(input logic [1:0] m, input logic [SW-1:0] s,
                                 input logic [W-1:0] d, input logic [TW-1:0] t);
    res_t r;
    int sh;
    sh = int'(s);
    r.data = '0;
    r.sticky = 1'b0;
    r.tag = t;
    for (int i = 0; i < W; i++) begin
      case (m)
        SHIFT_LSL: r.data[i] = (i >= sh) ? d[i-sh] : 1'b0;
        SHIFT_LSR: r.data[i] = (i + sh < W) ? d[i+sh] : 1'b0;
        SHIFT_ASR: r.data[i] = (i + sh < W) ? d[i+sh] : d[W-1];
        default:   r.data[i] = d[(i+sh)%W];
      endcase
      if ((m == SHIFT_LSR || m == SHIFT_ASR) && i < sh) r.sticky |= d[i];
    end
    r.zero = (r.data == '0);
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: scoreboard, hold stability, stall/ordering bookkeeping.
  initial begin
    bit   hold_prev;
    res_t held;
    res_t e;
    hold_prev = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        exp_q.delete();
        hold_prev = 0;
      end else begin
        if (hold_prev) begin
          checks++;
          if (!out_valid || out_data !== held.data || out_sticky !== held.sticky ||
              out_zero !== held.zero || out_tag !== held.tag) begin
            errors++;
            $display("FAIL hold: got v=%b d=%h s=%b z=%b t=%h expected v=1 d=%h s=%b z=%b t=%h",
                     out_valid, out_data, out_sticky, out_zero, out_tag,
                     held.data, held.sticky, held.zero, held.tag);
          end
        end
        if (out_valid && out_ready) begin
          n_out++;
          out_cycles.push_back(cyc);
          got_tags.push_back(out_tag);
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got d=%h t=%h expected no result", out_data, out_tag);
          end else begin
            e = exp_q.pop_front();
            if (out_data !== e.data || out_sticky !== e.sticky || out_zero !== e.zero ||
                out_tag !== e.tag) begin
              errors++;
              $display("FAIL result: got d=%h s=%b z=%b t=%h expected d=%h s=%b z=%b t=%h",
                       out_data, out_sticky, out_zero, out_tag, e.data, e.sticky, e.zero, e.tag);
            end
          end
        end
        if (in_valid && !in_ready) saw_stall = 1;
        if (in_valid && in_ready) exp_q.push_back(model(in_mode, in_shamt, in_data, in_tag));
        hold_prev = out_valid && !out_ready;
        held.data = out_data;
        held.sticky = out_sticky;
        held.zero = out_zero;
        held.tag = out_tag;
      end
    end
  end

  // Holds in_valid with the given operation until accepted; returns at posedge+1.
  task automatic send(input logic [1:0] m, input logic [SW-1:0] s, input logic [W-1:0] d,
                      input logic [TW-1:0] t, output int unsigned acc);
    bit ok;
    ok = 0;
    acc = 0;
    in_valid = 1'b1;
    in_mode = m;
    in_shamt = s;
    in_data = d;
    in_tag = t;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = cyc;
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for 200 cycles expected accept");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output int unsigned oc);
    bit ok;
    ok = 0;
    oc = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (out_valid) begin
        oc = cyc;
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      errors++;
      $display("FAIL out_timeout: got out_valid=0 for 50 cycles expected a result");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1);
  end

  initial begin
    int unsigned acc, oc, n0;
    bit drv_done;
    logic [TW-1:0] exp_tag;

    vecs[0]  = '{SHIFT_LSR, 7'd1,   64'h8000_0000_0000_0001, 64'h4000_0000_0000_0000, 1'b1, 1'b0};
    vecs[1]  = '{SHIFT_ASR, 7'd70,  64'hF000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vecs[2]  = '{SHIFT_LSL, 7'd12,  64'h0000_0000_0000_00FF, 64'h0000_0000_000F_F000, 1'b0, 1'b0};
    vecs[3]  = '{SHIFT_ROR, 7'd65,  64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000, 1'b0, 1'b0};
    vecs[4]  = '{SHIFT_LSR, 7'd0,   64'h0000_0000_0000_0123, 64'h0000_0000_0000_0123, 1'b0, 1'b0};
    vecs[5]  = '{SHIFT_LSR, 7'd64,  64'hDEAD_BEEF_0000_0001, 64'h0000_0000_0000_0000, 1'b1, 1'b1};
    vecs[6]  = '{SHIFT_LSL, 7'd63,  64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000, 1'b0, 1'b0};
    vecs[7]  = '{SHIFT_ASR, 7'd63,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[8]  = '{SHIFT_LSR, 7'd4,   64'h0000_0000_0000_00FF, 64'h0000_0000_0000_000F, 1'b1, 1'b0};
    vecs[9]  = '{SHIFT_ROR, 7'd8,   64'h0123_4567_89AB_CDEF, 64'hEF01_2345_6789_ABCD, 1'b0, 1'b0};
    vecs[10] = '{SHIFT_LSL, 7'd127, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 1'b0, 1'b1};
    vecs[11] = '{SHIFT_ASR, 7'd127, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 1'b1, 1'b1};

    // Reset values
    reset_n = 1'b1;
    #3 reset_n = 1'b0;
    #1;
    check("reset_out_valid", W'(out_valid), W'(0));
    check("reset_out_data", out_data, '0);
    check("reset_out_sticky", W'(out_sticky), W'(0));
    check("reset_out_zero", W'(out_zero), W'(1));
    check("reset_out_tag", W'(out_tag), W'(0));
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", W'(in_ready), W'(1));
    @(posedge clk);
    #1 out_ready = 1'b1;

    // Directed table, one operation at a time
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].mode, vecs[i].shamt, vecs[i].data, TW'(i), acc);
      in_valid = 1'b0;
      wait_out(oc);
      check($sformatf("vec%0d_latency", i), W'(oc - acc), W'(2));
      check($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
      check($sformatf("vec%0d_sticky", i), W'(out_sticky), W'(vecs[i].exp_sticky));
      check($sformatf("vec%0d_zero", i), W'(out_zero), W'(vecs[i].exp_zero));
      idle(1);
    end
    idle(3);

    // Backpressure: five back-to-back LSR ops, consumer stalls 3 cycles after the first
    saw_stall = 0;
    got_tags.delete();
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 5; i++)
          send(SHIFT_LSR, SW'($urandom_range(0, 127)), {$urandom, $urandom}, TW'(i), acc);
        in_valid = 1'b0;
      end
      begin
        wait_out(oc);
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(10);
    check("bp_count", W'(n_out - n0), W'(5));
    check("bp_in_ready_dropped", W'(saw_stall), W'(1));
    for (int i = 0; i < 5; i++) begin
      exp_tag = TW'(i);
      check($sformatf("bp_tag%0d", i),
            (got_tags.size() > i) ? W'(got_tags[i]) : W'(16'hDEAD), W'(exp_tag));
    end

    // Full throughput: 16 ops on 16 consecutive cycles
    saw_stall = 0;
    out_cycles.delete();
    for (int i = 0; i < 16; i++)
      send(2'($urandom_range(0, 3)), SW'($urandom_range(0, 127)), {$urandom, $urandom},
           TW'(i), acc);
    in_valid = 1'b0;
    idle(6);
    check("tp_count", W'(out_cycles.size()), W'(16));
    check("tp_consecutive", (out_cycles.size() == 16) ? W'(out_cycles[15] - out_cycles[0]) :
          W'(0), W'(15));
    check("tp_no_stall", W'(saw_stall), W'(0));

    // Random traffic with random backpressure
    n0 = n_out;
    drv_done = 0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          send(2'($urandom_range(0, 3)), SW'($urandom_range(0, 127)),
               ($urandom_range(0, 7) == 0) ? W'($urandom) : {$urandom, $urandom},
               TW'($urandom), acc);
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            idle(1);
          end
        end
        in_valid = 1'b0;
        drv_done = 1;
      end
      begin
        while (!drv_done) begin
          out_ready = ($urandom_range(0, 2) != 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) idle(1);
    idle(2);
    check("rand_drained", W'(exp_q.size()), W'(0));
    check("rand_count", W'(n_out - n0), W'(150));

    // Reset with two operations in flight
    send(SHIFT_LSR, 7'd3, 64'h0000_0000_0000_00F8, 4'hA, acc);
    send(SHIFT_ASR, 7'd9, 64'h8000_0000_0000_0100, 4'hB, acc);
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midreset_out_valid", W'(out_valid), W'(0));
    check("midreset_out_zero", W'(out_zero), W'(1));
    check("midreset_out_tag", W'(out_tag), W'(0));
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("midreset_in_ready", W'(in_ready), W'(1));
    n0 = n_out;
    oc = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) oc++;
    end
    check("midreset_no_stale", W'(oc), W'(0));
    check("midreset_no_output", W'(n_out - n0), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_pipelined_shifter.md
Name: fpu_pipelined_shifter

Overview:
- Parametrised, two-stage pipelined barrel shifter for the FPU8087 datapath.
- Successor to the fixed 64-bit, 0-7-bit combinational shifters. Adds:
  - configurable width and shift range;
  - four shift modes;
  - an IEEE sticky bit for rounding;
  - a tag sideband;
  - a valid/ready handshake with backpressure.
- Used for mantissa alignment before add/subtract and for normalisation after it.

Parameters:
- WIDTH, 64, data width in bits. Must be a multiple of 8 and at least 16.
- SHIFT_W, 7, shift-amount width. Maximum requested shift is 2^SHIFT_W-1.
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  an operation is offered on the in_* lines.
- in_ready  out  1  the shifter accepts the operation this cycle.
- in_data  in  WIDTH  operand.
- in_shamt  in  SHIFT_W  shift amount.
- in_mode  in  2  shift mode: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- in_tag  in  TAG_W  sideband tag, returned unchanged.
- out_valid  out  1  a result is presented on the out_* lines.
- out_ready  in  1  the consumer takes the result this cycle.
- out_data  out  WIDTH  shifted result.
- out_sticky  out  1  OR of every bit discarded by LSR or ASR.
- out_zero  out  1  out_data == 0.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset:
  - Asynchronous on reset_n low: both stage-valid flags clear; out_valid=0, out_data=0, out_sticky=0, out_zero=1, out_tag=0.
  - in_ready=1 from the first cycle after reset is released.
  - Asserting reset mid-operation silently drops every operation in flight; nothing is output afterwards.
- Handshake:
  - Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
  - s2_adv = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_adv. This is combinational, with no dependence on in_valid.
  - While out_valid && !out_ready, every out_* signal is held stable.
  - Throughput is one operation per cycle. Latency is exactly 2 cycles from accept to out_valid when there is no backpressure.
  - Results are delivered in order. No operation is lost or duplicated under any out_ready pattern.
- Stage 1 (coarse):
  - Shifts by 8*in_shamt[SHIFT_W-1:3] in the selected mode.
  - Registers: data, fine amount in_shamt[2:0], mode, tag, partial sticky (OR of the bits discarded so far).
- Stage 2 (fine):
  - Shifts the stage-1 data by 0-7 in the same mode.
  - Computes final sticky = partial sticky | OR of the bits discarded here.
  - Registers the outputs.
- Modes:
  - LSL: zero-fill from the LSB; out_sticky=0.
  - LSR: zero-fill from the MSB; sticky per the rule above.
  - ASR: fill with in_data[WIDTH-1]; sticky as for LSR.
  - ROR: rotate right by in_shamt mod WIDTH; the modulo is resolved in stage 1. out_sticky=0.
- Boundaries:
  - shamt=0: data passes through unchanged, out_sticky=0.
  - shamt >= WIDTH, LSL or LSR: out_data=0.
  - shamt >= WIDTH, ASR: out_data = all copies of the sign bit.
  - shamt >= WIDTH, LSR or ASR: out_sticky = |in_data.
  - shamt = WIDTH-1 behaves as an ordinary shift, with no saturation.
- Simultaneous events: an accept and an output drain in the same cycle with the pipeline full must both complete, with no bubble inserted.

Decomposition:
- Package fpu_shift_pkg holds:
  - the mode constants SHIFT_LSL, SHIFT_LSR, SHIFT_ASR, SHIFT_ROR (2-bit);
  - the coarse step constant SHIFT_COARSE_STEP=8.
- One sub-module, fpu_shift_fine_stage:
  - combinational 0-7 shift in all four modes, parametrised by WIDTH;
  - outputs the shifted data and the sticky for the discarded bits;
  - instantiated once in stage 2.
- The top level owns the coarse logic, the pipeline registers and the handshake.

Test Plan:
- LSR, data=64'h8000_0000_0000_0001, shamt=1, out_ready=1 -> out_data=64'h4000_0000_0000_0000, out_sticky=1, out_valid exactly 2 cycles after accept.
- ASR, data=64'hF000_0000_0000_0000, shamt=70 -> out_data=64'hFFFF_FFFF_FFFF_FFFF, out_sticky=1, out_zero=0.
- LSL, data=64'h0000_0000_0000_00FF, shamt=12 -> out_data=64'h0000_0000_000F_F000, out_sticky=0. ROR, data=64'h1, shamt=65 -> out_data=64'h8000_0000_0000_0000.
- Backpressure: 5 back-to-back LSR ops with tags 0-4 and out_ready low for 3 cycles after the first result -> in_ready drops, outputs stay stable, tags emerge in order 0-4, no loss or duplication.
- Full throughput: in_valid=1 and out_ready=1 for 16 cycles with random ops -> 16 results on consecutive cycles, all matching a reference model.
- Reset pulse with 2 ops in flight -> out_valid=0 immediately, in_ready=1 after release, no stale result ever appears.
